// File: rtl/s444_bist_pkg.sv
// s444 logic-BIST shared types and constants.
// LFSR taps are x^8+x^6+x^5+x^4+1 in Fibonacci form; the MISR uses CRC-16-CCITT.
package s444_bist_pkg;

    typedef enum logic [2:0] {IDLE, INIT, RUN, DRAIN, DONE} state_t;

    localparam int MISR_W    = 16;
    localparam int CUT_IN_W  = 3;
    localparam int CUT_OUT_W = 6;
    localparam int LFSR_W    = 8;

    localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
    localparam logic [MISR_W-1:0] MISR_POLY = 16'h1021;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[LFSR_W-2:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/s444_bist_ctrl_misr.sv
// Generic multiple-input signature register with sync clear and enable.
// upd is the unconditional next signature so callers can compare ahead of the edge.
module bist_misr #(
    parameter int          W    = 16,
    parameter int          IN_W = 6,
    parameter logic [W-1:0] POLY = 16'h1021
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic            en,
    input  logic [IN_W-1:0] din,
    output logic [W-1:0]    q,
    output logic [W-1:0]    upd
);

    assign upd = {q[W-2:0], 1'b0} ^ (q[W-1] ? POLY : '0) ^ W'(din);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= upd;
        end
    end

endmodule

// File: rtl/s444_bist_ctrl.sv
// Logic-BIST sequencer for the s444 core: INIT, LFSR patterns, MISR compaction,
// then a golden-signature compare. Core inputs are registered to avoid glitches.
module s444_bist_ctrl
    import s444_bist_pkg::*;
#(
    parameter int                N_PAT     = 255,
    parameter int                INIT_CYC  = 4,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'h01,
    parameter logic [MISR_W-1:0] GOLDEN    = 16'h0000
) (
    input  logic                 CK,
    input  logic                 RST,
    input  logic                 start,
    input  logic [CUT_OUT_W-1:0] cut_out,
    output logic                 bist_mode,
    output logic                 cut_g0,
    output logic                 cut_g1,
    output logic                 cut_g2,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [MISR_W-1:0]    signature
);

    // The counter is shared by INIT and RUN, so it must hold the larger span.
    localparam int CNT_MAX = (N_PAT > INIT_CYC) ? N_PAT : INIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t              state, state_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic [LFSR_W-1:0]   lfsr, lfsr_nxt;
    logic                mode_nxt;
    logic [CUT_IN_W-1:0] pins, pins_nxt;
    logic                pass_nxt;
    logic                misr_clr, misr_en;
    logic [MISR_W-1:0]   misr_upd;

    bist_misr #(
        .W    (MISR_W),
        .IN_W (CUT_OUT_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .clk (CK),
        .rst (RST),
        .clr (misr_clr),
        .en  (misr_en),
        .din (cut_out),
        .q   (signature),
        .upd (misr_upd)
    );

    assign {cut_g2, cut_g1, cut_g0} = pins;
    assign busy = (state == INIT) || (state == RUN) || (state == DRAIN);
    assign done = (state == DONE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lfsr_nxt  = lfsr;
        mode_nxt  = bist_mode;
        pins_nxt  = pins;
        pass_nxt  = pass;
        misr_clr  = 1'b0;
        misr_en   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = INIT;
                    cnt_nxt   = '0;
                    lfsr_nxt  = LFSR_SEED;
                    misr_clr  = 1'b1;
                    mode_nxt  = 1'b1;
                    pins_nxt  = 3'b001;
                    pass_nxt  = 1'b0;
                end
            end
            INIT: begin
                if (cnt == CNT_W'(INIT_CYC - 1)) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                    pins_nxt  = lfsr[CUT_IN_W-1:0];
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            RUN: begin
                misr_en  = 1'b1;
                lfsr_nxt = lfsr_step(lfsr);
                if (cnt == CNT_W'(N_PAT - 1)) begin
                    state_nxt = DRAIN;
                end else begin
                    cnt_nxt  = cnt + CNT_W'(1);
                    pins_nxt = lfsr_nxt[CUT_IN_W-1:0];
                end
            end
            DRAIN: begin
                misr_en   = 1'b1;
                state_nxt = DONE;
                mode_nxt  = 1'b0;
                pins_nxt  = '0;
                pass_nxt  = (misr_upd == GOLDEN);
            end
            default: ;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            lfsr      <= LFSR_SEED;
            bist_mode <= 1'b0;
            pins      <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lfsr      <= lfsr_nxt;
            bist_mode <= mode_nxt;
            pins      <= pins_nxt;
            pass      <= pass_nxt;
        end
    end

endmodule

// File: tb/tb_s444_bist_ctrl.sv
// Bench for s444_bist_ctrl: a default instance and a short N_PAT=4 instance
// checked cycle by cycle against a cycle-index reference model.
module tb_s444_bist_ctrl;

    localparam int IA = 4;
    localparam int NA = 255;
    localparam int IB = 2;
    localparam int NB = 4;
    localparam logic [15:0] GA = 16'h0000;
    localparam logic [15:0] GB = 16'h0010;
    localparam int TMAX = IA + NA + 3;

    logic CK = 1'b0;
    logic RST = 1'b1;
    logic start_a = 1'b0;
    logic start_b = 1'b0;
    logic [5:0] cut_a = '0;
    logic [5:0] cut_b = '0;

    logic mode_a, g0_a, g1_a, g2_a, busy_a, done_a, pass_a;
    logic mode_b, g0_b, g1_b, g2_b, busy_b, done_b, pass_b;
    logic [15:0] sig_a, sig_b;
    logic [22:0] obs_a, obs_b;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  pat [0:NA];
    logic [5:0]  hist_a [0:TMAX];
    logic [5:0]  hist_b [0:TMAX];
    logic [15:0] sig_run1 = '0;

    s444_bist_ctrl #(
        .N_PAT(NA), .INIT_CYC(IA), .LFSR_SEED(8'h01), .GOLDEN(GA)
    ) u_dut_a (
        .CK(CK), .RST(RST), .start(start_a), .cut_out(cut_a),
        .bist_mode(mode_a), .cut_g0(g0_a), .cut_g1(g1_a), .cut_g2(g2_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a)
    );

    s444_bist_ctrl #(
        .N_PAT(NB), .INIT_CYC(IB), .LFSR_SEED(8'h01), .GOLDEN(GB)
    ) u_dut_b (
        .CK(CK), .RST(RST), .start(start_b), .cut_out(cut_b),
        .bist_mode(mode_b), .cut_g0(g0_b), .cut_g1(g1_b), .cut_g2(g2_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b)
    );

    assign obs_a = {mode_a, g2_a, g1_a, g0_a, busy_a, done_a, pass_a, sig_a};
    assign obs_b = {mode_b, g2_b, g1_b, g0_b, busy_b, done_b, pass_b, sig_b};

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] lstep(input logic [7:0] l);
        logic fb;
        fb = l[7] ^ l[5] ^ l[4] ^ l[3];
        return {l[6:0], fb};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] d);
        logic [15:0] r;
        r = m << 1;
        if (m[15]) r = r ^ 16'h1021;
        return r ^ {10'b0, d};
    endfunction

    // Expected {mode,g2,g1,g0,busy,done,pass,sig} in cycle t after start.
    function automatic logic [22:0] expv(input int t, input int ic, input int np,
                                         input logic [15:0] g, input logic [15:0] s);
        logic [7:0] p;
        if (t <= ic) return {1'b1, 3'b001, 3'b100, s};
        if (t <= ic + np + 1) begin
            p = pat[(t <= ic + np) ? (t - ic - 1) : (np - 1)];
            return {1'b1, p[2:0], 3'b100, s};
        end
        return {4'b0000, 2'b01, (s == g), s};
    endfunction

    // mode 0: random A / single-hit B; 1: zero A / random B; 2: replay mode-0 data.
    task automatic run(input int mode, input int abort_t);
        logic [15:0] ma, mb;
        int first_done;
        ma = '0;
        mb = '0;
        first_done = -1;
        @(negedge CK);
        start_a = 1'b1;
        start_b = 1'b1;
        for (int t = 1; t <= TMAX; t++) begin
            @(negedge CK);
            start_a = 1'b0;
            start_b = 1'b0;
            chk("cyc_a", 32'(obs_a), 32'(expv(t, IA, NA, GA, ma)));
            chk("cyc_b", 32'(obs_b), 32'(expv(t, IB, NB, GB, mb)));
            if (done_a && first_done < 0) first_done = t;
            if (t == abort_t) begin
                #2 RST = 1'b1;
                #1;
                chk("rst_a", 32'(obs_a), 32'd0);
                chk("rst_b", 32'(obs_b), 32'd0);
                #1 RST = 1'b0;
                return;
            end
            if (mode >= 1 && (t == IA + 10 || t == IA + 100)) start_a = 1'b1;
            if (mode == 0) begin
                cut_a = 6'($urandom);
                cut_b = (t == IB + 1) ? 6'h01 : 6'h00;
                hist_a[t] = cut_a;
                hist_b[t] = cut_b;
            end else if (mode == 1) begin
                cut_a = 6'h00;
                cut_b = 6'($urandom);
            end else begin
                cut_a = hist_a[t];
                cut_b = hist_b[t];
            end
            if (t >= IA + 1 && t <= IA + NA + 1) ma = misr_step(ma, cut_a);
            if (t >= IB + 1 && t <= IB + NB + 1) mb = misr_step(mb, cut_b);
        end
        chk("latency", 32'(first_done), 32'(IA + NA + 2));
        if (mode == 0) sig_run1 = ma;
        if (mode == 2) chk("replay_sig", 32'(sig_a), 32'(sig_run1));
    endtask

    initial begin
        pat[0] = 8'h01;
        for (int k = 1; k <= NA; k++) pat[k] = lstep(pat[k-1]);
        #12 RST = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CK);
            chk("idle_a", 32'(obs_a), 32'd0);
            chk("idle_b", 32'(obs_b), 32'd0);
        end
        run(0, 0);
        run(1, 0);
        run(2, 0);
        run(0, IA + 30);
        run(0, 0);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
